// File: rtl/qdma_mem_responder_pkg.sv
// Shared definitions for the QDMA memory responder: default geometry,
// address/beat widths and the responder state encoding.
package qdma_mem_responder_pkg;

  localparam int NUM_MOD_DEF = 4;
  localparam int DEPTH_DEF   = 32;
  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W      = 5;
  localparam int MOD_W       = 3;
  localparam int BEAT_W      = ADDR_W + 1;
  localparam int WAIT_W      = 8;
  localparam int MAX_BANKS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Next address within one bank; wraps at the top so it never carries into the module id.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a, input int depth);
    return (int'(a) == depth - 1) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/qdma_mem_responder_bank.sv
// One memory module: single-port DEPTH x DATA_W array with a registered read port.
// Reset clears only the read register; array contents survive reset.
module qdma_mem_bank
  import qdma_mem_responder_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/qdma_mem_responder.sv
// DMA-facing memory responder: accepts one burst at a time, inserts WAIT_CYCLES
// wait states, then streams read beats or consumes write beats from up to four banks.
module qdma_mem_responder
  import qdma_mem_responder_pkg::*;
#(
  parameter int NUM_MOD     = NUM_MOD_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              gnt,
  input  logic              we,
  input  logic [MOD_W-1:0]  mod_sel,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] blen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              done,
  output logic              err,
  output state_e            dbg_state
);

  // Handshakes: a request is taken on a clock edge where req && gnt; a write beat
  // is taken on an edge where wvalid && wready; rvalid is a one-cycle, unstallable strobe.
  state_e              state_q;
  logic                gnt_q, wready_q, rvalid_q, done_q, err_q;
  logic                we_q;
  logic [MOD_W-1:0]    mod_q;
  logic [ADDR_W-1:0]   addr_q, blen_q, addr_nxt;
  logic [BEAT_W-1:0]   beat_q, beat_end;
  logic [WAIT_W-1:0]   wait_q;
  logic                rd_issue, wr_fire;
  logic [MAX_BANKS-1:0] bank_re, bank_we;
  logic [DATA_W-1:0]   bank_rdata [MAX_BANKS];

  assign addr_nxt = wrap_inc(addr_q, DEPTH);
  assign beat_end = {1'b0, blen_q} + BEAT_W'(1);
  // Reads keep XFER for one extra drain cycle so done trails the last rvalid.
  assign rd_issue = (state_q == ST_XFER) && !we_q && (beat_q != beat_end);
  assign wr_fire  = (state_q == ST_XFER) && we_q && wready_q && wvalid;

  always_comb begin
    bank_re = '0;
    bank_we = '0;
    rdata   = '0;
    for (int k = 0; k < MAX_BANKS; k++) begin
      if (int'(mod_q) == k) begin
        bank_re[k] = rd_issue;
        bank_we[k] = wr_fire;
        rdata      = bank_rdata[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 1'b1;
      wready_q <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      mod_q    <= '0;
      addr_q   <= '0;
      blen_q   <= '0;
      beat_q   <= '0;
      wait_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q   <= we;
            mod_q  <= mod_sel;
            addr_q <= addr;
            blen_q <= blen;
            beat_q <= '0;
            wait_q <= '0;
            gnt_q  <= 1'b0;
            if (int'(mod_sel) >= NUM_MOD) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (WAIT_CYCLES > 0) begin
              state_q <= ST_WAIT;
            end else begin
              state_q  <= ST_XFER;
              wready_q <= we;
            end
          end
        end
        ST_WAIT: begin
          wait_q <= wait_q + WAIT_W'(1);
          if (wait_q == WAIT_W'(WAIT_CYCLES - 1)) begin
            state_q  <= ST_XFER;
            wready_q <= we_q;
          end
        end
        ST_XFER: begin
          if (we_q) begin
            if (wr_fire) begin
              addr_q <= addr_nxt;
              beat_q <= beat_q + BEAT_W'(1);
              if (beat_q == {1'b0, blen_q}) begin
                wready_q <= 1'b0;
                state_q  <= ST_DONE;
                done_q   <= 1'b1;
              end
            end
          end else if (rd_issue) begin
            rvalid_q <= 1'b1;
            addr_q   <= addr_nxt;
            beat_q   <= beat_q + BEAT_W'(1);
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          gnt_q   <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  qdma_mem_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W)) memory0 (
    .clk(clk), .rst(rst), .re(bank_re[0]), .we(bank_we[0]),
    .addr(addr_q), .wdata(wdata), .rdata(bank_rdata[0]));
  qdma_mem_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W)) memory1 (
    .clk(clk), .rst(rst), .re(bank_re[1]), .we(bank_we[1]),
    .addr(addr_q), .wdata(wdata), .rdata(bank_rdata[1]));
  qdma_mem_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W)) memory2 (
    .clk(clk), .rst(rst), .re(bank_re[2]), .we(bank_we[2]),
    .addr(addr_q), .wdata(wdata), .rdata(bank_rdata[2]));
  qdma_mem_bank #(.DEPTH(DEPTH), .DATA_W(DATA_W)) memory3 (
    .clk(clk), .rst(rst), .re(bank_re[3]), .we(bank_we[3]),
    .addr(addr_q), .wdata(wdata), .rdata(bank_rdata[3]));

  assign gnt       = gnt_q;
  assign wready    = wready_q;
  assign rvalid    = rvalid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_qdma_mem_responder.sv
// Bench for qdma_mem_responder: directed bursts, expected beats/err pushed to queues,
// a negedge monitor pops and compares; memory contents checked against a bench model.
`timescale 1ns/1ps
module tb_qdma_mem_responder;
  import qdma_mem_responder_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0, we = 1'b0, wvalid = 1'b0;
  logic [2:0] mod_sel = '0;
  logic [4:0] addr = '0, blen = '0;
  logic [7:0] wdata = '0;
  logic       gnt, wready, rvalid, done, err;
  logic [7:0] rdata;
  state_e     dbg_state;

  logic       req_x = 1'b0, wvalid_x = 1'b0;
  logic       gnt0, wready0, rvalid0, done0, err0;
  logic       gnt3, wready3, rvalid3, done3, err3;
  logic [7:0] rdata0, rdata3;
  state_e     st0, st3;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  qdma_mem_responder #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .we(we), .mod_sel(mod_sel),
    .addr(addr), .blen(blen), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .done(done), .err(err), .dbg_state(dbg_state));

  qdma_mem_responder #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .req(req_x), .gnt(gnt0), .we(we), .mod_sel(mod_sel),
    .addr(addr), .blen(blen), .wdata(wdata), .wvalid(wvalid_x), .wready(wready0),
    .rdata(rdata0), .rvalid(rvalid0), .done(done0), .err(err0), .dbg_state(st0));

  qdma_mem_responder #(.WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst), .req(req_x), .gnt(gnt3), .we(we), .mod_sel(mod_sel),
    .addr(addr), .blen(blen), .wdata(wdata), .wvalid(wvalid_x), .wready(wready3),
    .rdata(rdata3), .rvalid(rvalid3), .done(done3), .err(err3), .dbg_state(st3));

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic       exp_err_q[$];
  logic [7:0] model [4][32];
  logic [7:0] wbuf [32];
  int n_tests = 0, n_fail = 0;
  int rv_cnt = 0, first_rv = -1, last_rv = -1, done_cnt = 0, done_cyc = -1;
  event mon_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid) begin
        if (rv_cnt == 0) first_rv = cyc;
        last_rv = cyc;
        rv_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rdata_unexpected: got 0x%0h with no beat expected", rdata);
        end else check("rdata", rdata, exp_q.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_err_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_unexpected: got done=1 err=%0b with none expected", err);
        end else check("err", err, exp_err_q.pop_front());
      end
    end
    -> mon_ev;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(mon_ev);
  endtask

  function automatic logic [7:0] peek(input int m, input int a);
    case (m)
      0:       return dut.memory0.mem[a];
      1:       return dut.memory1.mem[a];
      2:       return dut.memory2.mem[a];
      default: return dut.memory3.mem[a];
    endcase
  endfunction

  task automatic check_mem(input string name);
    int bad;
    bad = 0;
    for (int m = 0; m < 4; m++)
      for (int a = 0; a < 32; a++)
        if (peek(m, a) !== model[m][a]) bad++;
    check(name, bad, 0);
  endtask

  task automatic issue(input logic w, input logic [2:0] m, input logic [4:0] a,
                       input logic [4:0] b, output int acc);
    int g;
    g = 0;
    req = 1'b1; we = w; mod_sel = m; addr = a; blen = b;
    while (!gnt && g < 50) begin step(); g++; end
    check("gnt_before_accept", gnt, 1);
    step();
    acc = cyc;
    req = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int g;
    g = 0;
    while (done_cnt == d0 && g < 150) begin step(); g++; end
    check(name, done_cnt - d0, 1);
  endtask

  task automatic drive_beat(input logic [7:0] d);
    int g;
    g = 0;
    wvalid = 1'b1; wdata = d;
    while (!wready && g < 50) begin step(); g++; end
    check("wready_seen", wready, 1);
    step();
    wvalid = 1'b0;
  endtask

  task automatic rd_xfer(input int m, input int a, input int b);
    int acc, d0;
    rv_cnt = 0; first_rv = -1; last_rv = -1;
    for (int i = 0; i <= b; i++) exp_q.push_back(model[m][(a + i) % 32]);
    exp_err_q.push_back(1'b0);
    d0 = done_cnt;
    issue(1'b0, 3'(m), 5'(a), 5'(b), acc);
    check("gnt_busy", gnt, 0);
    wait_done(d0, "rd_done_seen");
    check("rd_beats", rv_cnt, b + 1);
    check("rd_latency", first_rv - acc, 2);
    check("rd_consecutive", last_rv - first_rv, b);
    check("rd_done_after_last", done_cyc - last_rv, 1);
    step();
    check("done_one_cycle", done, 0);
    check("gnt_back", gnt, 1);
  endtask

  task automatic wr_xfer(input int m, input int a, input int b, input int gap_at);
    int acc, d0;
    rv_cnt = 0;
    exp_err_q.push_back(1'b0);
    d0 = done_cnt;
    issue(1'b1, 3'(m), 5'(a), 5'(b), acc);
    for (int i = 0; i <= b; i++) begin
      if (i == gap_at) begin wvalid = 1'b0; step(); end
      drive_beat(wbuf[i]);
      model[m][(a + i) % 32] = wbuf[i];
    end
    wait_done(d0, "wr_done_seen");
    step();
    check("wr_done_once", done_cnt - d0, 1);
    check("wr_no_rvalid", rv_cnt, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc, d0, f0, f3, n0, n3;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_gnt", gnt, 1);
    check("rst_wready", wready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Preload every bank through the write path; bank 2 holds i+1.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) wbuf[i] = (k == 2) ? 8'(i + 1) : 8'(k * 64 + i * 3);
      wr_xfer(k, 0, 31, 99);
    end
    check_mem("mem_preload");
    check("mem2_10_preload", peek(2, 10), 8'd11);

    // Single-beat read: rdata 11.
    rd_xfer(2, 10, 0);

    // Four-beat write with one wvalid gap.
    wbuf[0] = 8'hA1; wbuf[1] = 8'hA2; wbuf[2] = 8'hA3; wbuf[3] = 8'hA4;
    wr_xfer(3, 15, 3, 2);
    check("mem3_15", peek(3, 15), 8'hA1);
    check("mem3_16", peek(3, 16), 8'hA2);
    check("mem3_17", peek(3, 17), 8'hA3);
    check("mem3_18", peek(3, 18), 8'hA4);
    check_mem("mem_after_write");

    // Wrapping read: 31, 32, 1, 2.
    rd_xfer(2, 30, 3);

    // Invalid module id.
    rv_cnt = 0;
    exp_err_q.push_back(1'b1);
    d0 = done_cnt;
    issue(1'b0, 3'd5, 5'd0, 5'd0, acc);
    wait_done(d0, "inv_done_seen");
    check("inv_done_latency", done_cyc - acc, 0);
    step();
    check("inv_done_one_cycle", done, 0);
    check("inv_err_clear", err, 0);
    check("inv_no_rvalid", rv_cnt, 0);
    check_mem("mem_after_invalid");

    // Reset after the second beat of a four-beat write to bank 1.
    d0 = done_cnt;
    issue(1'b1, 3'd1, 5'd4, 5'd3, acc);
    drive_beat(8'h55); model[1][4] = 8'h55;
    drive_beat(8'h66); model[1][5] = 8'h66;
    rst = 1'b1;
    step();
    check("abort_gnt", gnt, 1);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_wready", wready, 0);
    rst = 1'b0;
    repeat (4) step();
    check("abort_no_done", done_cnt - d0, 0);
    check("mem1_5_kept", peek(1, 5), 8'h66);
    check_mem("mem_after_abort");
    rd_xfer(1, 3, 2);

    // req held high through a transfer must not start a second one.
    exp_q.push_back(model[0][7]); exp_q.push_back(model[0][8]);
    exp_err_q.push_back(1'b0);
    rv_cnt = 0;
    d0 = done_cnt;
    issue(1'b0, 3'd0, 5'd7, 5'd1, acc);
    req = 1'b1; we = 1'b1; mod_sel = 3'd1; addr = 5'd0; blen = 5'd0;
    wait_done(d0, "busy_done_seen");
    req = 1'b0;
    repeat (5) step();
    check("busy_req_ignored", done_cnt - d0, 1);
    check("busy_beats", rv_cnt, 2);
    check_mem("mem_after_busy_req");

    // Wait-state latency of the 0 and 3 builds.
    we = 1'b0; mod_sel = 3'd0; addr = 5'd0; blen = 5'd0;
    req_x = 1'b1;
    step();
    acc = cyc;
    req_x = 1'b0;
    f0 = -1; f3 = -1; n0 = 0; n3 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rvalid0 && f0 < 0) f0 = cyc - acc;
      if (rvalid3 && f3 < 0) f3 = cyc - acc;
      if (done0) n0++;
      if (done3) n3++;
    end
    check("lat_wait0", f0, 1);
    check("lat_wait3", f3, 4);
    check("done_wait0", n0, 1);
    check("done_wait3", n3, 1);

    check("exp_q_drained", exp_q.size(), 0);
    check("exp_err_q_drained", exp_err_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_tests++; n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
